// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int unsigned XLEN            = 32;
    localparam logic [XLEN-1:0] INSTR_NOP   = 32'h0000_0013;
    localparam int unsigned ARB_TIMEOUT_DEF = 16;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'b00,
        ARB_FETCH = 2'b01,
        ARB_DATA  = 2'b10
    } arb_state_e;

    // Request captured at grant and replayed to memory for the whole access
    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } arb_req_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side (fetch, data) and memory-side handshake bundle of the arbiter.
interface mem_port_arbiter_if;
    import mem_port_arbiter_pkg::*;

    logic            if_req_i;
    logic [XLEN-1:0] if_addr_i;
    logic            if_valid_o;
    logic [XLEN-1:0] if_rdata_o;
    logic            dm_req_i;
    logic            dm_we_i;
    logic [XLEN-1:0] dm_addr_i;
    logic [XLEN-1:0] dm_wdata_i;
    logic            dm_valid_o;
    logic [XLEN-1:0] dm_rdata_o;
    logic            mem_req_o;
    logic            mem_we_o;
    logic [XLEN-1:0] mem_addr_o;
    logic [XLEN-1:0] mem_wdata_o;
    logic            mem_ready_i;
    logic [XLEN-1:0] mem_rdata_i;
    logic            err_o;

    modport slave (
        input  if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
               mem_ready_i, mem_rdata_i,
        output if_valid_o, if_rdata_o, dm_valid_o, dm_rdata_o,
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, err_o
    );

    modport master (
        output if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
               mem_ready_i, mem_rdata_i,
        input  if_valid_o, if_rdata_o, dm_valid_o, dm_rdata_o,
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, err_o
    );

endinterface

// File: rtl/mem_port_arbiter_watchdog.sv
// Per-access watchdog: counts un-ready busy cycles, clears on grant/finish,
// flags expiry in the last allowed cycle.
module mem_port_arbiter_watchdog
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic busy_i,
    input  logic ready_i,
    input  logic clr_i,
    output logic expire_o
);

    localparam int unsigned CNT_W = 8;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (busy_i && !ready_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = busy_i && !ready_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access.
// Optional ARB_PERF_CNT_EN adds a saturating conflict-cycle counter output.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    mem_port_arbiter_if.slave bus
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [XLEN-1:0] perf_conflict_o
`endif
);

    arb_state_e state_q, state_d;
    arb_req_t   req_q, req_d;
    arb_req_t   if_sel, dm_sel;
    logic       err_q, err_d;
    logic       busy, expire, done, grant;

    assign if_sel = '{we: 1'b0, addr: bus.if_addr_i, wdata: '0};
    assign dm_sel = '{we: bus.dm_we_i, addr: bus.dm_addr_i, wdata: bus.dm_wdata_i};
    assign busy   = (state_q != ARB_IDLE);
    assign done   = busy && (bus.mem_ready_i || expire);
    assign err_d  = err_q || expire;

    mem_port_arbiter_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_arb_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .busy_i  (busy),
        .ready_i (bus.mem_ready_i),
        .clr_i   (grant || done),
        .expire_o(expire)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            req_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            err_q   <= err_d;
        end
    end

    // On completion only the other requester may be granted, so no double grant
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        grant   = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (bus.dm_req_i) begin
                    state_d = ARB_DATA;
                    req_d   = dm_sel;
                    grant   = 1'b1;
                end else if (bus.if_req_i) begin
                    state_d = ARB_FETCH;
                    req_d   = if_sel;
                    grant   = 1'b1;
                end
            end
            ARB_FETCH: begin
                if (done) begin
                    if (bus.dm_req_i) begin
                        state_d = ARB_DATA;
                        req_d   = dm_sel;
                        grant   = 1'b1;
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end
            end
            ARB_DATA: begin
                if (done) begin
                    if (bus.if_req_i) begin
                        state_d = ARB_FETCH;
                        req_d   = if_sel;
                        grant   = 1'b1;
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Completion data is forwarded combinationally; everything is forced low in reset
    always_comb begin
        bus.mem_req_o   = 1'b0;
        bus.mem_we_o    = 1'b0;
        bus.mem_addr_o  = '0;
        bus.mem_wdata_o = '0;
        bus.if_valid_o  = 1'b0;
        bus.if_rdata_o  = '0;
        bus.dm_valid_o  = 1'b0;
        bus.dm_rdata_o  = '0;
        bus.err_o       = 1'b0;
        if (rst_n) begin
            bus.mem_req_o   = busy;
            bus.mem_we_o    = (state_q == ARB_DATA) && req_q.we;
            bus.mem_addr_o  = req_q.addr;
            bus.mem_wdata_o = req_q.wdata;
            bus.err_o       = err_q;
            if ((state_q == ARB_FETCH) && done) begin
                bus.if_valid_o = 1'b1;
                bus.if_rdata_o = bus.mem_ready_i ? bus.mem_rdata_i : INSTR_NOP;
            end
            if ((state_q == ARB_DATA) && done) begin
                bus.dm_valid_o = 1'b1;
                if (!req_q.we && bus.mem_ready_i) begin
                    bus.dm_rdata_o = bus.mem_rdata_i;
                end
            end
        end
    end

`ifdef ARB_PERF_CNT_EN
    logic            conflict;
    logic [XLEN-1:0] perf_q, perf_d;

    // A requester is waiting when it is high but does not own the port
    assign conflict = (bus.if_req_i && ((state_q == ARB_DATA) ||
                                        ((state_q == ARB_IDLE) && bus.dm_req_i))) ||
                      (bus.dm_req_i && (state_q == ARB_FETCH));
    assign perf_d   = (conflict && (perf_q != '1)) ? perf_q + XLEN'(1) : perf_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_conflict_o = perf_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench: transaction-level requester/memory model with a scoreboard
// predicting grant order, completion cycle, returned data and the error flag.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int unsigned TO   = ARB_TIMEOUT_DEF;
    localparam int          NCYC = 4000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();
`ifdef ARB_PERF_CNT_EN
    logic [XLEN-1:0] perf_conflict;
`endif

    mem_port_arbiter #(
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
`ifdef ARB_PERF_CNT_EN
        ,
        .perf_conflict_o(perf_conflict)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [XLEN-1:0] mem [logic [XLEN-1:0]];
    int              owner, done_at, cyc;
    bit              tout, m_we, err_exp, if_pend, dm_pend, did_rst;
    logic [XLEN-1:0] m_addr, m_wdata, perf_exp;

    task automatic check_eq(input string tag, input logic [XLEN-1:0] obs,
                            input logic [XLEN-1:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    function automatic logic [XLEN-1:0] mem_rd(input logic [XLEN-1:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[15:0] ^ 16'hA5A5, a[15:0]};
    endfunction

    function automatic logic [XLEN-1:0] rand_addr();
        return XLEN'($urandom_range(0, 15)) << 2;
    endfunction

    task automatic check_quiet(input string tag);
        check_eq({tag, "_mem_req"},  XLEN'(bus.mem_req_o),  '0);
        check_eq({tag, "_mem_we"},   XLEN'(bus.mem_we_o),   '0);
        check_eq({tag, "_mem_addr"}, bus.mem_addr_o,        '0);
        check_eq({tag, "_mem_wd"},   bus.mem_wdata_o,       '0);
        check_eq({tag, "_if_valid"}, XLEN'(bus.if_valid_o), '0);
        check_eq({tag, "_if_rdata"}, bus.if_rdata_o,        '0);
        check_eq({tag, "_dm_valid"}, XLEN'(bus.dm_valid_o), '0);
        check_eq({tag, "_dm_rdata"}, bus.dm_rdata_o,        '0);
        check_eq({tag, "_err"},      XLEN'(bus.err_o),      '0);
    endtask

    // New access: capture the winner and decide how long memory will take
    task automatic start_access(input int who);
        int r, w;
        owner = who;
        if (who == 2) begin
            m_addr = bus.dm_addr_i; m_we = bus.dm_we_i; m_wdata = bus.dm_wdata_i;
        end else begin
            m_addr = bus.if_addr_i; m_we = 1'b0; m_wdata = '0;
        end
        r = int'($urandom_range(0, 19));
        if (r < 14)      w = r % 4;
        else if (r < 16) w = int'(TO) - 1;
        else if (r < 17) w = int'(TO) - 2;
        else             w = 1000;
        done_at = cyc + 1 + ((w > int'(TO) - 1) ? int'(TO) - 1 : w);
        tout    = (w >= int'(TO));
    endtask

    initial begin
        bit              busy_e, done_e, ifv_e, dmv_e, conflict;
        logic [XLEN-1:0] ifr_e, dmr_e;

        owner = 0; cyc = 0; done_at = 0; tout = 0; m_we = 0; err_exp = 0;
        if_pend = 0; dm_pend = 0; did_rst = 0; m_addr = '0; m_wdata = '0; perf_exp = '0;
        bus.if_req_i = 0; bus.if_addr_i = '0; bus.dm_req_i = 0; bus.dm_we_i = 0;
        bus.dm_addr_i = '0; bus.dm_wdata_i = '0; bus.mem_ready_i = 0; bus.mem_rdata_i = '0;

        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            bus.mem_ready_i = 1'b1;
            #1 check_quiet("reset");
        end
        bus.mem_ready_i = 1'b0;
        rst_n = 1'b1;

        while (cyc < NCYC) begin
            @(posedge clk); #1;
            cyc++;

            if (!did_rst && cyc >= 1500 && owner == 2) begin
                did_rst = 1; rst_n = 1'b0;
                bus.if_req_i = 0; bus.dm_req_i = 0; bus.mem_ready_i = 1'b1;
                #1 check_quiet("rst_hold");
                @(posedge clk); #1;
                rst_n = 1'b1; bus.mem_ready_i = 1'b0;
                #1 check_quiet("rst_after");
                @(posedge clk); #1;
                bus.mem_ready_i = 1'b1; bus.mem_rdata_i = $urandom;
                #1 check_quiet("late_ready");
                owner = 0; err_exp = 0; if_pend = 0; dm_pend = 0; perf_exp = '0;
                continue;
            end

            if (!if_pend && $urandom_range(0, 2) == 0) begin
                if_pend = 1; bus.if_addr_i = rand_addr();
            end
            if (!dm_pend && $urandom_range(0, 2) == 0) begin
                dm_pend = 1; bus.dm_addr_i = rand_addr();
                bus.dm_we_i = 1'($urandom_range(0, 1)); bus.dm_wdata_i = $urandom;
            end
            bus.if_req_i = if_pend;
            bus.dm_req_i = dm_pend;

            busy_e = (owner != 0);
            done_e = busy_e && (cyc == done_at);
            bus.mem_ready_i = busy_e ? (done_e && !tout) : ($urandom_range(0, 3) == 0);
            bus.mem_rdata_i = (busy_e && bus.mem_ready_i) ? mem_rd(bus.mem_addr_o) : $urandom;
            #1;

            ifv_e = done_e && (owner == 1);
            dmv_e = done_e && (owner == 2);
            ifr_e = !ifv_e ? '0 : (tout ? INSTR_NOP : mem_rd(m_addr));
            dmr_e = (!dmv_e || m_we || tout) ? '0 : mem_rd(m_addr);
            check_eq("mem_req", XLEN'(bus.mem_req_o), XLEN'(busy_e));
            check_eq("mem_we",  XLEN'(bus.mem_we_o),  XLEN'(owner == 2 && m_we));
            if (busy_e) check_eq("mem_addr", bus.mem_addr_o, m_addr);
            if (owner == 2 && m_we) check_eq("mem_wdata", bus.mem_wdata_o, m_wdata);
            check_eq("if_valid", XLEN'(bus.if_valid_o), XLEN'(ifv_e));
            check_eq("if_rdata", bus.if_rdata_o, ifr_e);
            check_eq("dm_valid", XLEN'(bus.dm_valid_o), XLEN'(dmv_e));
            check_eq("dm_rdata", bus.dm_rdata_o, dmr_e);
            check_eq("err", XLEN'(bus.err_o), XLEN'(err_exp));
`ifdef ARB_PERF_CNT_EN
            check_eq("perf", perf_conflict, perf_exp);
`endif

            conflict = (if_pend && owner != 1 && (owner != 0 || dm_pend)) ||
                       (dm_pend && owner == 1);
            if (conflict && perf_exp != '1) perf_exp = perf_exp + XLEN'(1);

            if (done_e) begin
                if (tout) err_exp = 1;
                else if (owner == 2 && m_we) mem[m_addr] = m_wdata;
                if (owner == 1) begin
                    if_pend = 0;
                    if (dm_pend) start_access(2); else owner = 0;
                end else begin
                    dm_pend = 0;
                    if (if_pend) start_access(1); else owner = 0;
                end
            end else if (owner == 0) begin
                if (dm_pend)      start_access(2);
                else if (if_pend) start_access(1);
            end
        end

        check_eq("mid_reset_seen", XLEN'(did_rst), XLEN'(1));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
